// File: rtl/ifq_pkg.sv
// Shared definitions for the IF/ID fetch queue: the bubble instruction,
// the default-width queue entry type and the occupancy-width helper.
package ifq_pkg;

    // addi x0, x0, 0 -- presented to decode whenever the queue is empty
    localparam logic [31:0] IFQ_NOP_INST = 32'h0000_0013;

    localparam int IFQ_XLEN = 64;
    localparam int IFQ_ILEN = 32;

    // One queue slot at the default widths: PC in the upper bits, instruction below
    typedef struct packed {
        logic [IFQ_XLEN-1:0] pc;
        logic [IFQ_ILEN-1:0] inst;
    } ifq_entry_t;

    // Occupancy runs 0..depth inclusive, so it needs clog2(depth+1) bits
    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifq_ptr.sv
// Wrap-around pointer for the fetch queue. The width is clog2(DEPTH) with
// DEPTH a power of two, so the natural binary overflow is the modulo-DEPTH wrap.
module ifq_ptr #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;

    // Pointer register: clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue_if_id.sv
// IF/ID boundary implemented as a DEPTH-entry circular instruction queue.
// Optional macro IFQ_FULL_PUSHPOP_EN: when defined, a full queue accepts a
// push in the same cycle decode pops, at the cost of an out_ready->in_ready path.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high and no flush is requested; valid never waits on ready, and the
// producer holds its data until the transfer completes.
module fetch_queue_if_id
    import ifq_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               XLEN     = 64,
    parameter int               ILEN     = 32,
    parameter logic [ILEN-1:0]  NOP_INST = ILEN'(IFQ_NOP_INST)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          bj_en,
    input  logic                          trap_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ILEN-1:0]               inst_in,
    input  logic [XLEN-1:0]               pc_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ILEN-1:0]               inst_out,
    output logic [XLEN-1:0]               pc_out,
    output logic [ifq_cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = ifq_cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_wr_ptr;
    logic [PW-1:0]   w_rd_ptr;
    logic            w_flush;
    logic            w_not_full;
    logic            w_push;
    logic            w_pop;
    entry_t          w_head;

    // Any redirect source empties the queue and wins over push/pop
    assign w_flush    = clear | bj_en | trap_en;
    assign w_not_full = (r_count != FULL_CNT);

`ifdef IFQ_FULL_PUSHPOP_EN
    assign in_ready = w_not_full | (out_ready & ~w_flush);
`else
    assign in_ready = w_not_full;
`endif

    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~w_flush;
    assign w_pop     = out_valid & out_ready & ~w_flush;

    ifq_ptr #(.PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_flush),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    ifq_ptr #(.PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_flush),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    // Storage write: slots are not reset, only the count says what is live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= '{pc: pc_in, inst: inst_in};
        end
    end

    // Occupancy: flush empties; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign count  = r_count;
    assign w_head = r_mem[w_rd_ptr];

    // Head presentation: bubble instruction and zero PC when nothing is queued
    always_comb begin
        inst_out = NOP_INST;
        pc_out   = '0;
        if (out_valid) begin
            inst_out = w_head.inst;
            pc_out   = w_head.pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_not_full && !w_pop))
        else $error("push into full fetch queue");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && (r_count == '0)))
        else $error("pop from empty fetch queue");

endmodule

// File: tb/tb_fetch_queue_if_id.sv
// Bench for fetch_queue_if_id (DEPTH=4, XLEN=64, ILEN=32): directed vectors,
// a scoreboard queue of expected {pc, inst} entries and a negedge monitor.
module tb_fetch_queue_if_id;
    import ifq_pkg::*;

    localparam int W = $bits(ifq_entry_t);

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear, bj_en, trap_en;
    logic        in_valid, in_ready;
    logic [31:0] inst_in;
    logic [63:0] pc_in;
    logic        out_valid, out_ready;
    logic [31:0] inst_out;
    logic [63:0] pc_out;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue_if_id #(.DEPTH(4), .XLEN(64), .ILEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .bj_en     (bj_en),
        .trap_en   (trap_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_in   (inst_in),
        .pc_in     (pc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_out  (inst_out),
        .pc_out    (pc_out),
        .count     (count)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head transfer must match the oldest expectation
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && out_valid && out_ready && !(clear | bj_en | trap_en)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop got_pc=%h got_inst=%h want=none", pc_out, inst_out);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", {pc_out, inst_out}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        bj_en     = 1'b0;
        trap_en   = 1'b0;
        inst_in   = '0;
        pc_in     = '0;
    endtask

    task automatic drive(input logic [63:0] pc);
        in_valid = 1'b1;
        pc_in    = pc;
        inst_in  = {16'hC0DE, pc[15:0]};
    endtask

    task automatic expect_push();
        exp_q.push_back({pc_in, inst_in});
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_count"}, W'(count), W'(0));
        chk({name, "_valid"}, W'(out_valid), W'(0));
        chk({name, "_inst"},  W'(inst_out), W'(32'h13));
        chk({name, "_pc"},    W'(pc_out), W'(0));
    endtask

    // Watchdog: the directed flow is a fixed number of cycles
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic       exp_rdy;
    logic [2:0] exp_cnt;

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk_empty("reset");
        chk("reset_in_ready", W'(in_ready), W'(1));
        tick();
        tick();
        rst_n = 1'b1;

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(64'h1000 + 64'(4 * i));
            expect_push();
            tick();
        end
        chk("full_count", W'(count), W'(4));
        chk("full_in_ready", W'(in_ready), W'(0));
        drive(64'h1010);
        tick();
        chk("fifth_refused_count", W'(count), W'(4));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk_empty("drained");

        // Decode ready on an empty queue: no pop, bubble presented
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_empty("empty_pop");
        end

        // Streaming push+pop, wrapping the pointers past index 3
        for (int i = 0; i < 10; i++) begin
            drive(64'h2000 + 64'(4 * i));
            expect_push();
            tick();
            chk("stream_count", W'(count), W'(1));
            if (i == 0) begin
                chk("stream_first_valid", W'(out_valid), W'(1));
                chk("stream_first_pc", W'(pc_out), W'(64'h2000));
            end
        end
        in_valid = 1'b0;
        tick();
        chk_empty("stream_end");
        out_ready = 1'b0;

        // Flush priority: bj_en, clear, trap_en in turn
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) begin
                drive(64'h3000 + 64'(k * 256) + 64'(4 * i));
                expect_push();
                tick();
            end
            chk("preflush_count", W'(count), W'(2));
            drive(64'hDEAD0 + 64'(k));
            out_ready = 1'b1;
            bj_en     = (k == 0);
            clear     = (k == 1);
            trap_en   = (k == 2);
            tick();
            exp_q.delete();
            idle();
            chk_empty("postflush");
            drive(64'h3800 + 64'(k));
            expect_push();
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            chk("after_flush_count", W'(count), W'(0));
            out_ready = 1'b0;
        end

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            drive(64'h4000 + 64'(4 * i));
            expect_push();
            tick();
        end
        drive(64'h4010);
        out_ready = 1'b1;
`ifdef IFQ_FULL_PUSHPOP_EN
        exp_rdy = 1'b1;
        exp_cnt = 3'd4;
        expect_push();
`else
        exp_rdy = 1'b0;
        exp_cnt = 3'd3;
`endif
        chk("full_pushpop_in_ready", W'(in_ready), W'(exp_rdy));
        tick();
        chk("full_pushpop_count", W'(count), W'(exp_cnt));
        in_valid = 1'b0;
        repeat (5) tick();
        chk_empty("full_pushpop_drained");
        out_ready = 1'b0;

        // Asynchronous reset between edges with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(64'h5000 + 64'(4 * i));
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count", W'(count), W'(3));
        #2 rst_n = 1'b0;
        #1;
        chk_empty("mid_reset");
        chk("mid_reset_in_ready", W'(in_ready), W'(1));
        tick();
        rst_n = 1'b1;
        tick();
        chk_empty("after_reset");

        chk("leftover_expected", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
